// File: rtl/dec_stage_if.sv
// Bus between the fetch/control side and the MIPS decode stage.
// Carries the fetched instruction, register-file write-back controls,
// write-back data, and the decoded read operands and immediate.
// Handshake: none. There is no valid/ready pair. Every input is taken as
// valid on every cycle. Writes commit on the rising clock edge. Read
// outputs are combinational and valid whenever the inputs are stable.
interface dec_stage_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       Instr;
   logic              RF_WrEn;
   logic              RF_WrData_sel;
   logic              RF_B_sel;
   logic [1:0]        ImmExt_sel;
   logic [DATA_W-1:0] ALU_out;
   logic [DATA_W-1:0] MEM_out;
   logic [DATA_W-1:0] RF_A;
   logic [DATA_W-1:0] RF_B;
   logic [DATA_W-1:0] Immed;

   // Fetch/control side: drives the instruction and the write-back.
   modport master (
      output Instr, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt_sel, ALU_out, MEM_out,
      input  RF_A, RF_B, Immed
   );

   // Decode stage: consumes the controls and produces the operands.
   modport slave (
      input  Instr, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt_sel, ALU_out, MEM_out,
      output RF_A, RF_B, Immed
   );
endinterface

// File: rtl/dec_stage.sv
// MIPS instruction-decode stage.
// Contains a 32x32 register file with two combinational read ports and one
// write port. Register 0 always reads as zero. The stage also extends the
// 16-bit immediate.
// Optional feature macro: DEC_STAGE_RF_BYPASS_EN. When it is defined, a read
// port whose address matches the pending write address returns the write
// data in the same cycle (write-first forwarding).
module dec_stage #(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input logic        Clk,
   input logic        Reset,
   dec_stage_if.slave bus
);
   localparam int ADDR_W = 5;

   // Instruction fields. Note that this datapath names the [20:16] field
   // "rd" (the write address) and the [15:11] field "rt".
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rt;
   logic [15:0]       imm;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] imm_ext;
   logic              unused_opcode;

   logic [DATA_W-1:0] regs [REG_N];

   assign rs            = bus.Instr[25:21];
   assign rd            = bus.Instr[20:16];
   assign rt            = bus.Instr[15:11];
   assign imm           = bus.Instr[15:0];
   assign unused_opcode = &{1'b0, bus.Instr[31:26]};

   assign b_addr  = bus.RF_B_sel ? rd : rt;
   assign wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;

   // Register array: reset clears every entry and drops any write in that
   // cycle. A write only happens when it is enabled, so wr_data (and an
   // undriven select) is ignored while RF_WrEn is low. Entry 0 is never written.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < REG_N; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.RF_WrEn && (rd != '0)) begin
         regs[rd] <= wr_data;
      end
   end

   // Read port A: address rs. Address 0 reads as zero, with optional forwarding.
   always_comb begin
      rd_a = (rs == '0) ? '0 : regs[rs];
`ifdef DEC_STAGE_RF_BYPASS_EN
      if (bus.RF_WrEn && (rd != '0) && (rs == rd)) begin
         rd_a = wr_data;
      end
`endif
   end

   // Read port B: address rt or rd. Address 0 reads as zero, with optional forwarding.
   always_comb begin
      rd_b = (b_addr == '0) ? '0 : regs[b_addr];
`ifdef DEC_STAGE_RF_BYPASS_EN
      if (bus.RF_WrEn && (rd != '0) && (b_addr == rd)) begin
         rd_b = wr_data;
      end
`endif
   end

   // Immediate extension: a pure function of the instruction and the mode.
   always_comb begin
      imm_ext = {{16{imm[15]}}, imm};
      case (bus.ImmExt_sel)
         2'b00:   imm_ext = {{16{imm[15]}}, imm};
         2'b01:   imm_ext = {16'b0, imm};
         2'b10:   imm_ext = {imm, 16'b0};
         2'b11:   imm_ext = {{14{imm[15]}}, imm, 2'b00};
         default: imm_ext = {{16{imm[15]}}, imm};
      endcase
   end

   assign bus.RF_A  = rd_a;
   assign bus.RF_B  = rd_b;
   assign bus.Immed = imm_ext;
endmodule

// File: tb/tb_dec_stage.sv
// Testbench for dec_stage.
// The first part covers directed cases: reset, write-back sources,
// register 0, port-B addressing, immediate modes, same-cycle read/write,
// and reset dropping a write. The second part runs randomized cycles
// against an array model of the register file.
module tb_dec_stage;
   logic Clk;
   logic Reset;
   int   total;
   int   bad;

   dec_stage_if #(.DATA_W(32)) bus ();

   dec_stage #(.DATA_W(32), .REG_N(32)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   // Clock/reset block
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: the architectural register contents.
   logic [31:0] model_rf [32];

   // Scoreboard: values expected after each randomized write are queued here.
   logic [31:0] exp_q [$];

   function automatic logic [31:0] mk_instr(input logic [4:0] rs_f, input logic [4:0] rd_f,
                                            input logic [15:0] imm_f);
      return {6'b000000, rs_f, rd_f, imm_f};
   endfunction

   // Immediate extension computed with plain arithmetic.
   function automatic logic [31:0] model_imm(input logic [15:0] imm_f, input logic [1:0] mode);
      int signed s;
      s = int'($signed(imm_f));
      case (mode)
         2'd0:    return 32'(s);
         2'd1:    return 32'(int'(imm_f));
         2'd2:    return 32'(imm_f) * 32'd65536;
         default: return 32'(s * 4);
      endcase
   endfunction

   // Expected value of a read port, given the stimulus currently applied.
   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef DEC_STAGE_RF_BYPASS_EN
      if (bus.RF_WrEn && (a == bus.Instr[20:16]))
         return bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
`endif
      return model_rf[a];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Driver task
   task automatic drive(input logic [31:0] instr, input logic wren, input logic wsel,
                        input logic bsel, input logic [1:0] isel,
                        input logic [31:0] alu, input logic [31:0] mem);
      bus.Instr         = instr;
      bus.RF_WrEn       = wren;
      bus.RF_WrData_sel = wsel;
      bus.RF_B_sel      = bsel;
      bus.ImmExt_sel    = isel;
      bus.ALU_out       = alu;
      bus.MEM_out       = mem;
   endtask

   // Advance one clock edge. The model follows the architectural write rule
   // using the stimulus that was present at the edge.
   task automatic tick();
      logic        do_rst;
      logic        do_wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      do_rst = Reset;
      do_wr  = bus.RF_WrEn;
      wa     = bus.Instr[20:16];
      wd     = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
      @(posedge Clk);
      if (do_rst) begin
         for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      end else if (do_wr && wa != 5'd0) begin
         model_rf[wa] = wd;
      end
      #1;
   endtask

   task automatic read_a(input logic [4:0] a, input string tag, input logic [31:0] exp);
      drive(mk_instr(a, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      check(tag, bus.RF_A, exp);
   endtask

   initial begin
      logic [4:0]  r_rs;
      logic [4:0]  r_rd;
      logic [15:0] r_imm;
      logic [31:0] exp_v;
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      drive(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;

      // The register file reads zero after reset.
      for (int a = 0; a < 32; a += 5) read_a(5'(a), "reset_state", 32'h0);

      // A reset pulse clears a previously written register.
      drive(mk_instr(5'd0, 5'd5, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0);
      tick();
      read_a(5'd5, "r5_written", 32'hDEADBEEF);
      drive(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      read_a(5'd5, "r5_after_reset", 32'h0);

      // Write back from the ALU, then from memory.
      drive(32'h00A3_0000, 1'b1, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 32'h5555_AAAA);
      tick();
      read_a(5'd3, "wb_alu", 32'h1234_5678);
      drive(32'h00A3_0000, 1'b1, 1'b1, 1'b0, 2'b00, 32'h1234_5678, 32'hCAFE_0001);
      tick();
      read_a(5'd3, "wb_mem", 32'hCAFE_0001);

      // Register 0 ignores writes.
      drive(mk_instr(5'd0, 5'd0, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0);
      tick();
      drive(mk_instr(5'd0, 5'd0, 16'h0), 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      check("r0_a", bus.RF_A, 32'h0);
      check("r0_b", bus.RF_B, 32'h0);

      // Port-B addressing with r7 and r9.
      drive(mk_instr(5'd0, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'h77, 32'h0);
      tick();
      drive(mk_instr(5'd0, 5'd9, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'h99, 32'h0);
      tick();
      drive(mk_instr(5'd0, 5'd7, {5'd9, 11'h0}), 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #1;
      check("b_sel0", bus.RF_B, 32'h99);
      bus.RF_B_sel = 1'b1;
      #1;
      check("b_sel1", bus.RF_B, 32'h77);

      // Immediate modes with imm = 0x8004.
      drive(mk_instr(5'd0, 5'd0, 16'h8004), 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      #1 check("imm_sext", bus.Immed, 32'hFFFF_8004);
      bus.ImmExt_sel = 2'b01;
      #1 check("imm_zext", bus.Immed, 32'h0000_8004);
      bus.ImmExt_sel = 2'b10;
      #1 check("imm_upper", bus.Immed, 32'h8004_0000);
      bus.ImmExt_sel = 2'b11;
      #1 check("imm_sext_sh2", bus.Immed, 32'hFFFE_0010);

      // Same-cycle read and write of r4.
      drive(mk_instr(5'd0, 5'd4, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'h11, 32'h0);
      tick();
      drive(mk_instr(5'd4, 5'd4, 16'h0), 1'b1, 1'b0, 1'b1, 2'b00, 32'h22, 32'h0);
      #1;
`ifdef DEC_STAGE_RF_BYPASS_EN
      check("rw_same_a_pre", bus.RF_A, 32'h22);
      check("rw_same_b_pre", bus.RF_B, 32'h22);
`else
      check("rw_same_a_pre", bus.RF_A, 32'h11);
      check("rw_same_b_pre", bus.RF_B, 32'h11);
`endif
      tick();
      bus.RF_WrEn = 1'b0;
      #1 check("rw_same_post", bus.RF_A, 32'h22);

      // With RF_WrEn low, an undriven select does not disturb r4.
      drive(mk_instr(5'd4, 5'd4, 16'h0), 1'b0, 1'bx, 1'b0, 2'b00, 32'hBAD0_0001, 32'hBAD0_0002);
      tick();
      read_a(5'd4, "wren0_hold", 32'h22);

      // Reset drops a write requested in the same cycle.
      drive(mk_instr(5'd0, 5'd6, 16'h0), 1'b1, 1'b0, 1'b0, 2'b00, 32'h6666, 32'h0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      read_a(5'd6, "reset_drops_write", 32'h0);
      read_a(5'd4, "reset_clears_r4", 32'h0);

      // Randomized cycles checked against the model.
      for (int n = 0; n < 400; n++) begin
         r_rs  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r_rd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r_imm = 16'($urandom);
         if ($urandom_range(0, 1) == 0) r_imm[15:11] = 5'($urandom_range(0, 7));
         drive(mk_instr(r_rs, r_rd, r_imm), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
         Reset = ($urandom_range(0, 63) == 0);
         if (Reset) bus.RF_WrEn = 1'b0;
         #1;
         check("rand_rf_a", bus.RF_A, model_read(r_rs));
         check("rand_rf_b", bus.RF_B, model_read(bus.RF_B_sel ? r_rd : r_imm[15:11]));
         check("rand_immed", bus.Immed, model_imm(r_imm, bus.ImmExt_sel));
         if (bus.RF_WrEn && !Reset && r_rd != 5'd0)
            exp_q.push_back(bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out);
         tick();
         Reset = 1'b0;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            read_a(r_rd, "rand_writeback", exp_v);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
